alu_issue_ctrl: RTL

- Hardware initiator for the ALU datapath (ctrl/A/B in, 32-bit result out): accepts one operation request at a time, drives the ALU control and operand lines with the correct timing, collects results and returns them on a response handshake.
- MULTU is sequenced in hardware: run phase, settle gap, then MFHI and MFLO readouts, returned as two response beats.
- Sits between the decode stage and the ALU, replacing bench-driven sequencing.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_seq_counter.sv | 28 ++
 rtl/alu_issue_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: function codes, sequencer
// states and the request legality check.
package alu_pkg;

  localparam logic [5:0] OP_AND   = 6'd36;
  localparam logic [5:0] OP_OR    = 6'd37;
  localparam logic [5:0] OP_ADD   = 6'd32;
  localparam logic [5:0] OP_SUB   = 6'd34;
  localparam logic [5:0] OP_SLT   = 6'd42;
  localparam logic [5:0] OP_SRL   = 6'd2;
  localparam logic [5:0] OP_MULTU = 6'd25;
  localparam logic [5:0] OP_MFHI  = 6'd16;
  localparam logic [5:0] OP_MFLO  = 6'd18;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_EXEC,
    ST_CAPT,
    ST_MUL_RUN,
    ST_MUL_GAP,
    ST_RD_HI,
    ST_RD_LO,
    ST_RESP_HI,
    ST_RESP
  } state_t;

  // MFHI/MFLO are sequenced internally and are not accepted from the decoder.
  function automatic logic op_is_legal(input logic [5:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SRL, OP_MULTU: return 1'b1;
      default:                                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_counter.sv
// Cycle counter for the multiply run and settle phases: clears to zero and
// flags when the count reaches the supplied terminal value.
module alu_seq_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_val_i,
  output logic         term_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign term_o = (cnt_q == term_val_i);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one request at a time to the ALU, sequences MULTU/MFHI/MFLO in
// hardware and returns results on a buffered response handshake.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = 33,
  parameter int MUL_GAP    = 2,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [5:0]    req_op,
  input  logic [DW-1:0] req_a,
  input  logic [DW-1:0] req_b,
  output logic [5:0]    alu_ctrl,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_result,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  output logic          rsp_err
);

  localparam int CNT_MAX = (MUL_CYCLES > MUL_GAP) ? MUL_CYCLES : MUL_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t        state_q, state_d;
  logic [5:0]    ctrl_q, ctrl_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic          rsp_valid_q, rsp_valid_d, rsp_last_q, rsp_last_d, rsp_err_q, rsp_err_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d, lo_q, lo_d;
  logic          lo_pend_q, lo_pend_d;
  logic          cnt_clr, cnt_en, cnt_term;
  logic [CW-1:0] term_val;

  assign term_val = (state_q == ST_MUL_GAP) ? CW'(MUL_GAP - 1) : CW'(MUL_CYCLES - 1);

  alu_seq_counter #(.W(CW)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .term_val_i (term_val),
    .term_o     (cnt_term)
  );

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
    rsp_err_d   = rsp_err_q;
    lo_d        = lo_q;
    lo_pend_d   = lo_pend_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (!op_is_legal(req_op)) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_last_d  = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            ctrl_d = req_op;
            a_d    = req_a;
            b_d    = req_b;
            if (req_op == OP_MULTU) begin
              state_d = ST_MUL_RUN;
              cnt_clr = 1'b1;
            end else begin
              state_d = ST_EXEC;
            end
          end
        end
      end
      ST_EXEC: state_d = ST_CAPT;
      ST_CAPT: begin
        rsp_data_d  = alu_result;
        rsp_valid_d = 1'b1;
        rsp_last_d  = 1'b1;
        ctrl_d      = OP_AND;
        a_d         = '0;
        b_d         = '0;
        state_d     = ST_RESP;
      end
      ST_MUL_RUN: begin
        if (cnt_term) begin
          cnt_clr = 1'b1;
          ctrl_d  = OP_AND;
          a_d     = '0;
          b_d     = '0;
          state_d = ST_MUL_GAP;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_MUL_GAP: begin
        if (cnt_term) begin
          cnt_clr = 1'b1;
          ctrl_d  = OP_MFHI;
          state_d = ST_RD_HI;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RD_HI: begin
        ctrl_d  = OP_MFLO;
        state_d = ST_RD_LO;
      end
      // The ALU result trails alu_ctrl by one edge: HI is on alu_result here,
      // and LO appears during the first RESP_HI cycle.
      ST_RD_LO: begin
        ctrl_d      = OP_AND;
        rsp_data_d  = alu_result;
        rsp_valid_d = 1'b1;
        rsp_last_d  = 1'b0;
        lo_pend_d   = 1'b1;
        state_d     = ST_RESP_HI;
      end
      ST_RESP_HI: begin
        if (lo_pend_q) begin
          lo_d      = alu_result;
          lo_pend_d = 1'b0;
        end
        if (rsp_ready) begin
          rsp_data_d = lo_pend_q ? alu_result : lo_q;
          rsp_last_d = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_data_d  = '0;
          rsp_last_d  = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        ctrl_d  = OP_AND;
        a_d     = '0;
        b_d     = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ctrl_q      <= OP_AND;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      lo_q        <= '0;
      lo_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      rsp_err_q   <= rsp_err_d;
      lo_q        <= lo_d;
      lo_pend_q   <= lo_pend_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign alu_ctrl  = ctrl_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_err   = rsp_err_q;

endmodule
